// File: rtl/bht_ghist.sv
// Gshare conditional branch predictor: a flop-based counter table indexed by PC XOR speculative GHR,
// with mispredict repair of the GHR and a sequential clear sweep after reset or flush.
module bht_ghist #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NR_ENTRIES   = 128,
  parameter int unsigned NR_ROWS      = 2,
  parameter int unsigned HIST_BITS    = 3,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned INDEX_OFFSET = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  output logic                 ready_o,
  input  logic                 lookup_valid_i,
  input  logic [XLEN-1:0]      vpc_i,
  output logic [NR_ROWS-1:0]   pred_valid_o,
  output logic [NR_ROWS-1:0]   pred_taken_o,
  output logic [HIST_BITS-1:0] ghist_o,
  input  logic                 spec_push_i,
  input  logic                 spec_taken_i,
  input  logic                 upd_valid_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic [HIST_BITS-1:0] upd_ghist_i,
  input  logic                 upd_taken_i,
  input  logic                 mispredict_i
);

  localparam int unsigned NR_SETS  = NR_ENTRIES / NR_ROWS;
  localparam int unsigned SET_BITS = (NR_SETS > 1) ? $clog2(NR_SETS) : 1;
  localparam int unsigned ROW_BITS = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(NR_SETS - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                                     state_q;
  logic [SET_BITS-1:0]                        sweep_q;
  logic                                       ready_q;
  logic [HIST_BITS-1:0]                       ghist_q, ghist_d;
  logic [NR_SETS-1:0][NR_ROWS-1:0]            valid_q;
  logic [NR_SETS-1:0][NR_ROWS-1:0][CTR_BITS-1:0] ctr_q;

  logic [SET_BITS-1:0] lkp_set, upd_set;
  logic [ROW_BITS-1:0] upd_row;
  logic [CTR_BITS-1:0] upd_ctr_cur, upd_ctr_new;
  logic                upd_en, hist_en;

  wire unused_bits = ^{vpc_i, upd_pc_i};

  assign lkp_set = vpc_i[INDEX_OFFSET+ROW_BITS +: SET_BITS] ^ SET_BITS'(ghist_q);
  assign upd_set = upd_pc_i[INDEX_OFFSET+ROW_BITS +: SET_BITS] ^ SET_BITS'(upd_ghist_i);
  assign upd_row = upd_pc_i[INDEX_OFFSET +: ROW_BITS];

  assign hist_en = (state_q == ST_RUN) && !debug_mode_i && !flush_i;
  assign upd_en  = hist_en && upd_valid_i;

  // Saturating counter step and GHR next-state; the truncating cast also covers HIST_BITS == 1
  always_comb begin
    upd_ctr_cur = ctr_q[upd_set][upd_row];
    upd_ctr_new = upd_ctr_cur;
    if (upd_taken_i && (upd_ctr_cur != CTR_MAX)) begin
      upd_ctr_new = upd_ctr_cur + CTR_ONE;
    end else if (!upd_taken_i && (upd_ctr_cur != '0)) begin
      upd_ctr_new = upd_ctr_cur - CTR_ONE;
    end else begin
      upd_ctr_new = upd_ctr_cur;
    end

    ghist_d = ghist_q;
    if (upd_valid_i && mispredict_i) begin
      ghist_d = HIST_BITS'({upd_ghist_i, upd_taken_i});
    end else if (spec_push_i) begin
      ghist_d = HIST_BITS'({ghist_q, spec_taken_i});
    end else begin
      ghist_d = ghist_q;
    end
  end

  // Zero-latency lookup of all rows in the indexed set
  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    for (int r = 0; r < NR_ROWS; r++) begin
      pred_valid_o[r] = lookup_valid_i & ready_q & valid_q[lkp_set][r];
      pred_taken_o[r] = pred_valid_o[r] & ctr_q[lkp_set][r][CTR_BITS-1];
    end
  end

  // Init/run FSM with the single table write port shared by sweep and update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
      ghist_q <= '0;
    end else if (flush_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
      ghist_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          for (int r = 0; r < NR_ROWS; r++) begin
            valid_q[sweep_q][r] <= 1'b0;
            ctr_q[sweep_q][r]   <= CTR_INIT;
          end
          sweep_q <= sweep_q + SET_BITS'(1);
          if (sweep_q == SET_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (upd_en) begin
            valid_q[upd_set][upd_row] <= 1'b1;
            ctr_q[upd_set][upd_row]   <= upd_ctr_new;
          end
          if (hist_en) begin
            ghist_q <= ghist_d;
          end
        end
        default: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign ghist_o = ghist_q;

endmodule
